// File: rtl/my_cpu_pkg.sv
// ---------------------------------------------------------------------------
// my_cpu_pkg
// Shared definitions for the fetch front end:
//   - fetch_state_e : fetch FSM encoding (RUN / DRAIN / HALT)
//   - INST_W        : instruction / address width
//   - RESET_PC_DEFAULT : default fetch address after reset
//   - word_align / pc_misaligned : PC helper functions
// No ports (package).
// ---------------------------------------------------------------------------
package my_cpu_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'd0;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_DRAIN = 2'd1,
    FETCH_HALT  = 2'd2
  } fetch_state_e;

  // Force a byte address onto a 4-byte word boundary.
  function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  // True when the low two address bits are non-zero.
  function automatic logic pc_misaligned(input logic [INST_W-1:0] pc);
    return (pc & 32'h0000_0003) != 32'h0000_0000;
  endfunction

endpackage

// File: rtl/my_ifetch_fifo.sv
// ---------------------------------------------------------------------------
// my_ifetch_fifo
// Small circular queue with push, pop and synchronous flush. Used both as the
// instruction queue ({pc,data}) and as the outstanding-request PC tag queue.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   push, push_data     write one entry (ignored when full)
//   pop                 advance head (ignored when empty)
//   flush               empty the queue; wins over push/pop
//   head_data           oldest entry, read straight from storage registers
//   count               number of valid entries
// DEPTH need not be a power of two (pointers wrap explicitly).
// ---------------------------------------------------------------------------
module my_ifetch_fifo
  import my_cpu_pkg::*;
#(
  parameter int W     = 2 * INST_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Qualify push/pop against full/empty.
  always_comb begin
    do_push_s = push && (count_r != CW'(DEPTH));
    do_pop_s  = pop && (count_r != {CW{1'b0}});
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/my_ifetch.sv
// ---------------------------------------------------------------------------
// my_ifetch
// Instruction fetch stage: issues sequential word fetches, queues returned
// words with their PC and presents them to decode via valid/ready. A redirect
// flushes the queue and marks every in-flight response as stale so it is
// dropped on return.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   redirect_valid, redirect_pc        load a new fetch PC
//   imem_req_valid/ready/addr          request channel to instruction memory
//   imem_rsp_valid/data                in-order response channel
//   inst_valid/ready, inst_data/pc     queue head to decode
//   fetch_fault                        sticky misaligned-redirect flag
// Build option: define IFETCH_ALIGN_CHK_EN to trap misaligned redirects into
// HALT and raise fetch_fault; otherwise the low PC bits are ignored and
// fetch_fault is tied low.
// ---------------------------------------------------------------------------
module my_ifetch
  import my_cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  fetch_state_e  state_r;
  fetch_state_e  state_n;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   fetch_pc_n;
  logic [OW-1:0] stale_r;
  logic [OW-1:0] stale_n;
  logic [OW-1:0] stale_calc_s;
  logic          req_valid_r;
  logic          req_valid_n;

  logic          req_fire_s;
  logic          rsp_fire_s;
  logic          pop_fire_s;
  logic          q_push_s;
  logic          q_flush_s;
  logic [CW-1:0] q_count_s;
  logic [63:0]   q_head_s;
  logic [OW-1:0] outstanding_s;
  logic [31:0]   tag_pc_s;
  logic [31:0]   q_count_n_s;
  logic [31:0]   out_n_s;

`ifdef IFETCH_ALIGN_CHK_EN
  logic          fault_r;
  logic          fault_n;
`endif

  // Handshake qualifiers. Responses with nothing outstanding are ignored.
  always_comb begin
    req_fire_s   = req_valid_r && imem_req_ready;
    rsp_fire_s   = imem_rsp_valid && (outstanding_s != {OW{1'b0}});
    pop_fire_s   = (q_count_s != {CW{1'b0}}) && inst_ready;
    // Everything still in flight after this cycle becomes stale on a redirect.
    stale_calc_s = outstanding_s + OW'(req_fire_s) - OW'(rsp_fire_s);
  end

  // PC tags of outstanding requests; its occupancy is the outstanding count.
  // Never flushed: stale responses still retire their tag.
  my_ifetch_fifo #(
    .W     (32),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire_s),
    .push_data (fetch_pc_r),
    .pop       (rsp_fire_s),
    .flush     (1'b0),
    .head_data (tag_pc_s),
    .count     (outstanding_s)
  );

  // Instruction queue of {pc, data}.
  my_ifetch_fifo #(
    .W     (64),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push_s),
    .push_data ({tag_pc_s, imem_rsp_data}),
    .pop       (pop_fire_s),
    .flush     (q_flush_s),
    .head_data (q_head_s),
    .count     (q_count_s)
  );

  // Fetch FSM next state, PC, stale counter and queue control.
  always_comb begin
    state_n    = state_r;
    fetch_pc_n = fetch_pc_r;
    stale_n    = stale_r;
    q_push_s   = 1'b0;
    q_flush_s  = 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
    fault_n    = fault_r;
`endif
    if (redirect_valid) begin
      q_flush_s  = 1'b1;
      fetch_pc_n = word_align(redirect_pc);
      stale_n    = stale_calc_s;
      if (stale_calc_s == {OW{1'b0}}) begin
        state_n = FETCH_RUN;
      end else begin
        state_n = FETCH_DRAIN;
      end
`ifdef IFETCH_ALIGN_CHK_EN
      if (pc_misaligned(redirect_pc)) begin
        state_n = FETCH_HALT;
        fault_n = 1'b1;
      end else begin
        fault_n = 1'b0;
      end
`endif
    end else begin
      if (req_fire_s) begin
        fetch_pc_n = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_n = fetch_pc_r;
      end
      if (rsp_fire_s) begin
        if (stale_r == {OW{1'b0}}) begin
          q_push_s = 1'b1;
        end else begin
          stale_n = stale_r - OW'(1);
          // Last stale word gone: resume issuing (HALT stays put).
          if ((stale_r == OW'(1)) && (state_r == FETCH_DRAIN)) begin
            state_n = FETCH_RUN;
          end else begin
            state_n = state_r;
          end
        end
      end else begin
        stale_n = stale_r;
      end
    end
  end

  // Registered request-valid, computed from next-cycle occupancy so that
  // queued + in-flight never exceeds DEPTH (credit rule: a push never finds the queue full).
  always_comb begin
    if (q_flush_s) begin
      q_count_n_s = 32'd0;
    end else begin
      q_count_n_s = 32'(q_count_s) + 32'(q_push_s) - 32'(pop_fire_s);
    end
    out_n_s     = 32'(outstanding_s) + 32'(req_fire_s) - 32'(rsp_fire_s);
    req_valid_n = (state_n == FETCH_RUN) &&
                  ((q_count_n_s + out_n_s) < 32'(DEPTH)) &&
                  (out_n_s < 32'(MAX_OUT));
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= FETCH_RUN;
      fetch_pc_r  <= RESET_PC;
      stale_r     <= {OW{1'b0}};
      req_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      fetch_pc_r  <= fetch_pc_n;
      stale_r     <= stale_n;
      req_valid_r <= req_valid_n;
    end
  end

`ifdef IFETCH_ALIGN_CHK_EN
  // Sticky fault flag, cleared only by reset or an aligned redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= fault_n;
    end
  end
  assign fetch_fault = fault_r;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = fetch_pc_r;
  assign inst_valid     = (q_count_s != {CW{1'b0}});
  assign inst_pc        = q_head_s[63:32];
  assign inst_data      = q_head_s[31:0];

endmodule

// File: tb/tb_my_ifetch.sv
module tb_my_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          n_deliv  = 0;
  int          d0;
  logic [31:0] exp_pc;
  bit          rsp_en;
  logic [31:0] mem_q[$];

  always #5 clk = ~clk;

  my_ifetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // One clock: memory answers the oldest accepted request (>=1 cycle later),
  // deliveries are checked against the expected sequential PC stream.
  task automatic step();
    bit          fire;
    bit          rsp_now;
    logic [31:0] faddr;
    rsp_now        = rsp_en && (mem_q.size() > 0);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(mem_q[0]) : 32'd0;
    fire           = imem_req_valid && imem_req_ready;
    faddr          = imem_req_addr;
    if (inst_valid && inst_ready) begin
      chk("deliv_pc", inst_pc, exp_pc);
      chk("deliv_data", inst_data, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    @(posedge clk);
    @(negedge clk);
    if (rsp_now) void'(mem_q.pop_front());
    if (fire) mem_q.push_back(faddr);
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    inst_ready     = 1'b1;
    rsp_en         = 1'b1;
    exp_pc         = 32'd0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    rst_n = 1'b1;

    // Sequential streaming from RESET_PC
    step();
    chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c0_addr", imem_req_addr, 32'd0);
    step();
    chk("c1_addr", imem_req_addr, 32'd4);
    chk("c1_inst_valid", 32'(inst_valid), 32'd0);
    step();
    chk("c2_inst_valid", 32'(inst_valid), 32'd1);
    chk("c2_inst_pc", inst_pc, 32'd0);
    repeat (6) step();
    chk("stream_count", 32'(n_deliv), 32'd6);

    // Decode stall: queue fills to DEPTH, issue stops
    inst_ready = 1'b0;
    repeat (8) step();
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    chk("full_head_pc", inst_pc, exp_pc);
    imem_req_ready = 1'b0;
    inst_ready     = 1'b1;
    d0 = n_deliv;
    repeat (6) step();
    chk("buffered_words", 32'(n_deliv - d0), 32'd4);
    chk("hold_req_valid", 32'(imem_req_valid), 32'd1);
    chk("hold_addr_a", imem_req_addr, exp_pc);
    repeat (5) step();
    chk("hold_addr_b", imem_req_addr, exp_pc);
    chk("hold_inst_valid", 32'(inst_valid), 32'd0);
    imem_req_ready = 1'b1;
    d0 = n_deliv;
    repeat (6) step();
    chk("resume_count", 32'(n_deliv - d0), 32'd4);

    // Two outstanding, redirect to 0x100: both responses dropped
    rsp_en = 1'b0;
    repeat (4) step();
    chk("max_out_req_valid", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    exp_pc = 32'h0000_0100;
    chk("rd1_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rd1_inst_valid", 32'(inst_valid), 32'd0);
    rsp_en = 1'b1;
    step();
    chk("drain1_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    chk("drain2_req_valid", 32'(imem_req_valid), 32'd1);
    chk("drain2_addr", imem_req_addr, 32'h0000_0100);
    d0 = n_deliv;
    repeat (6) step();
    chk("rd1_count", 32'(n_deliv - d0), 32'd4);

    // Redirect coinciding with a request accept and a response
    chk("rd2_pre_req_valid", 32'(imem_req_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    exp_pc = 32'h0000_0200;
    chk("rd2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rd2_inst_valid", 32'(inst_valid), 32'd0);
    step();
    chk("rd2_resume_valid", 32'(imem_req_valid), 32'd1);
    chk("rd2_resume_addr", imem_req_addr, 32'h0000_0200);
    d0 = n_deliv;
    repeat (5) step();
    chk("rd2_count", 32'(n_deliv - d0), 32'd3);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
`ifdef IFETCH_ALIGN_CHK_EN
    exp_pc = 32'hDEAD_BEE0;
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (3) step();
    chk("halt_req_valid", 32'(imem_req_valid), 32'd0);
    chk("halt_inst_valid", 32'(inst_valid), 32'd0);
    chk("halt_fault", 32'(fetch_fault), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    exp_pc = 32'h0000_0200;
    chk("clr_fault", 32'(fetch_fault), 32'd0);
    chk("clr_req_valid", 32'(imem_req_valid), 32'd1);
    chk("clr_addr", imem_req_addr, 32'h0000_0200);
`else
    exp_pc = 32'h0000_0100;
    chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    chk("mis_fault", 32'(fetch_fault), 32'd0);
    chk("mis_resume_valid", 32'(imem_req_valid), 32'd1);
    chk("mis_addr", imem_req_addr, 32'h0000_0100);
`endif
    d0 = n_deliv;
    repeat (5) step();
    chk("mis_count", 32'(n_deliv - d0), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
